// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: arbitrates exceptions, mret and the external interrupt, then
// drives the CSR strobes, the pipeline flush and a single fetch redirect.
module trap_controller #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        exceptionValid,
   input  logic [3:0]  exceptionCause,
   input  logic [31:0] exceptionTval,
   input  logic [31:0] exceptionPC,
   input  logic        mretValid,
   input  logic        wbValid,
   input  logic [31:0] wbNextPC,
   input  logic        interrupt,
   input  logic        mstatusMIE,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        controlReset,
   output logic        mretSignal,
   output logic [3:0]  mcause,
   output logic        mcauseInterrupt,
   output logic [31:0] mtval,
   output logic [31:0] trapPC,
   output logic        pipelineFlush,
   output logic        redirectValid,
   output logic [31:0] redirectPC,
   output logic        busy
);

   typedef enum logic [2:0] {StIdle, StTrap, StReturn, StFlush, StRedirect} state_t;

   localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);

   state_t      state;
   logic [3:0]  flushCount;
   logic [1:0]  intSync;
   logic [31:0] trapBase;
   logic [31:0] trapTarget;
   logic        takeInterrupt;

   assign trapBase      = {mtvec[31:2], 2'b00};
   // Vectored mode only applies to interrupts; exceptions always go to the base.
   assign trapTarget    = (mtvec[1:0] == 2'b01 && mcauseInterrupt) ?
                          trapBase + {26'd0, mcause, 2'b00} : trapBase;
   assign takeInterrupt = intSync[1] && mstatusMIE && wbValid;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= StIdle;
         flushCount      <= 4'd0;
         intSync         <= 2'b00;
         controlReset    <= 1'b0;
         mretSignal      <= 1'b0;
         mcause          <= 4'd0;
         mcauseInterrupt <= 1'b0;
         mtval           <= 32'd0;
         trapPC          <= 32'd0;
         pipelineFlush   <= 1'b0;
         redirectValid   <= 1'b0;
         redirectPC      <= 32'd0;
         busy            <= 1'b0;
      end else begin
         intSync       <= {intSync[0], interrupt};
         controlReset  <= 1'b0;
         mretSignal    <= 1'b0;
         redirectValid <= 1'b0;
         case (state)
            StIdle: begin
               if (exceptionValid) begin
                  mcause          <= exceptionCause;
                  mtval           <= exceptionTval;
                  trapPC          <= exceptionPC;
                  mcauseInterrupt <= 1'b0;
                  controlReset    <= 1'b1;
                  pipelineFlush   <= 1'b1;
                  busy            <= 1'b1;
                  state           <= StTrap;
               end else if (mretValid) begin
                  mretSignal    <= 1'b1;
                  pipelineFlush <= 1'b1;
                  busy          <= 1'b1;
                  state         <= StReturn;
               end else if (takeInterrupt) begin
                  mcause          <= 4'd11;
                  mtval           <= 32'd0;
                  trapPC          <= wbNextPC;
                  mcauseInterrupt <= 1'b1;
                  controlReset    <= 1'b1;
                  pipelineFlush   <= 1'b1;
                  busy            <= 1'b1;
                  state           <= StTrap;
               end
            end
            StTrap: begin
               redirectPC <= trapTarget;
               flushCount <= FlushLoad;
               state      <= StFlush;
            end
            StReturn: begin
               redirectPC <= {mepc[31:2], 2'b00};
               flushCount <= FlushLoad;
               state      <= StFlush;
            end
            StFlush: begin
               flushCount <= flushCount - 4'd1;
               if (flushCount == 4'd1) begin
                  pipelineFlush <= 1'b0;
                  redirectValid <= 1'b1;
                  state         <= StRedirect;
               end
            end
            StRedirect: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               pipelineFlush <= 1'b0;
               busy          <= 1'b0;
               state         <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trap_controller.sv
// Directed and randomized checks of trap_controller against a cycle-offset reference model.
module tb_trap_controller;

   localparam int F = 2;

   logic        clock;
   logic        reset;
   logic        exceptionValid;
   logic [3:0]  exceptionCause;
   logic [31:0] exceptionTval;
   logic [31:0] exceptionPC;
   logic        mretValid;
   logic        wbValid;
   logic [31:0] wbNextPC;
   logic        interrupt;
   logic        mstatusMIE;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        controlReset;
   logic        mretSignal;
   logic [3:0]  mcause;
   logic        mcauseInterrupt;
   logic [31:0] mtval;
   logic [31:0] trapPC;
   logic        pipelineFlush;
   logic        redirectValid;
   logic [31:0] redirectPC;
   logic        busy;

   int n_checks = 0;
   int n_fail = 0;

   // Last captured trap record, as the CSR file should see it.
   logic [3:0]  m_cause;
   logic [31:0] m_tval;
   logic [31:0] m_pc;
   logic        m_irq;

   trap_controller #(.FLUSH_CYCLES(F)) dut (
      .clock(clock), .reset(reset),
      .exceptionValid(exceptionValid), .exceptionCause(exceptionCause),
      .exceptionTval(exceptionTval), .exceptionPC(exceptionPC),
      .mretValid(mretValid), .wbValid(wbValid), .wbNextPC(wbNextPC),
      .interrupt(interrupt), .mstatusMIE(mstatusMIE), .mtvec(mtvec), .mepc(mepc),
      .controlReset(controlReset), .mretSignal(mretSignal), .mcause(mcause),
      .mcauseInterrupt(mcauseInterrupt), .mtval(mtval), .trapPC(trapPC),
      .pipelineFlush(pipelineFlush), .redirectValid(redirectValid),
      .redirectPC(redirectPC), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_target(input bit is_mret);
      logic [31:0] base;
      if (is_mret) return mepc & 32'hFFFF_FFFC;
      base = mtvec & 32'hFFFF_FFFC;
      if (m_irq && (mtvec & 32'd3) == 32'd1) return base + 32'(m_cause) * 32'd4;
      return base;
   endfunction

   task automatic chk_record();
      chk32("mcause", {28'd0, mcause}, {28'd0, m_cause});
      chk32("mtval", mtval, m_tval);
      chk32("trapPC", trapPC, m_pc);
      chk1("mcauseInterrupt", mcauseInterrupt, m_irq);
   endtask

   // Called in the cycle right after the accepting edge (k=1); ends in the first idle cycle.
   task automatic check_timeline(input bit is_trap, input logic [31:0] target);
      for (int k = 1; k <= F + 3; k++) begin
         chk1("controlReset", controlReset, (k == 1) && is_trap);
         chk1("mretSignal", mretSignal, (k == 1) && !is_trap);
         chk1("pipelineFlush", pipelineFlush, k <= F + 1);
         chk1("redirectValid", redirectValid, k == F + 2);
         chk1("busy", busy, k <= F + 2);
         if (k >= 2 && k <= F + 2) chk32("redirectPC", redirectPC, target);
         chk_record();
         if (k < F + 3) begin
            // Wrong-path requests while busy must be dropped.
            exceptionValid = 1'($urandom_range(0, 1));
            exceptionCause = 4'($urandom);
            exceptionTval  = $urandom;
            exceptionPC    = $urandom;
            mretValid      = 1'($urandom_range(0, 1));
            step();
         end
      end
      exceptionValid = 1'b0;
      mretValid      = 1'b0;
   endtask

   task automatic run_txn(input int kind, input logic [3:0] cause, input logic [31:0] tval,
                          input logic [31:0] pc, input logic [31:0] nextpc);
      case (kind)
         0: begin
            exceptionValid = 1'b1;
            exceptionCause = cause;
            exceptionTval  = tval;
            exceptionPC    = pc;
            m_cause = cause;
            m_tval  = tval;
            m_pc    = pc;
            m_irq   = 1'b0;
         end
         1: begin
            mretValid      = 1'b1;
            exceptionCause = cause;
            exceptionTval  = tval;
            exceptionPC    = pc;
         end
         default: begin
            interrupt  = 1'b1;
            mstatusMIE = 1'b1;
            wbValid    = 1'b1;
            wbNextPC   = nextpc;
            step();
            chk1("irq_sync1_strobe", controlReset, 1'b0);
            step();
            chk1("irq_sync2_strobe", controlReset, 1'b0);
            m_cause = 4'd11;
            m_tval  = 32'd0;
            m_pc    = nextpc;
            m_irq   = 1'b1;
         end
      endcase
      step();
      exceptionValid = 1'b0;
      mretValid      = 1'b0;
      interrupt      = 1'b0;
      wbValid        = 1'b0;
      check_timeline(kind != 1, exp_target(kind == 1));
   endtask

   initial begin
      reset = 1'b0;
      exceptionValid = 1'b0; exceptionCause = 4'd0; exceptionTval = 32'd0; exceptionPC = 32'd0;
      mretValid = 1'b0; wbValid = 1'b0; wbNextPC = 32'd0; interrupt = 1'b0;
      mstatusMIE = 1'b0; mtvec = 32'd0; mepc = 32'd0;
      m_cause = 4'd0; m_tval = 32'd0; m_pc = 32'd0; m_irq = 1'b0;

      #2;
      chk1("rst_controlReset", controlReset, 1'b0);
      chk1("rst_mretSignal", mretSignal, 1'b0);
      chk1("rst_pipelineFlush", pipelineFlush, 1'b0);
      chk1("rst_redirectValid", redirectValid, 1'b0);
      chk32("rst_redirectPC", redirectPC, 32'd0);
      chk1("rst_busy", busy, 1'b0);
      chk_record();
      step();
      step();
      reset = 1'b1;
      step();

      // Exception into a direct vector.
      mtvec = 32'h80;
      run_txn(0, 4'd2, 32'hDEAD_BEEF, 32'h100, 32'd0);

      // mret returns to mepc and leaves the trap record alone.
      mepc = 32'h204;
      run_txn(1, 4'd9, 32'h1234_5678, 32'hABC, 32'd0);

      // Vectored interrupt: base 0x1000 + 11*4.
      mtvec = 32'h1001;
      run_txn(2, 4'd0, 32'd0, 32'd0, 32'h40);
      chk32("vec_target_const", redirectPC, 32'h102C);

      // Simultaneous exception, mret and pending interrupt.
      mtvec = 32'h2000;
      interrupt = 1'b1; mstatusMIE = 1'b0; wbValid = 1'b1; wbNextPC = 32'h600;
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("sim_pending_busy", busy, 1'b0);
      end
      exceptionValid = 1'b1; exceptionCause = 4'd7; exceptionTval = 32'h77;
      exceptionPC = 32'h500; mretValid = 1'b1; mstatusMIE = 1'b1;
      m_cause = 4'd7; m_tval = 32'h77; m_pc = 32'h500; m_irq = 1'b0;
      step();
      exceptionValid = 1'b0;
      mretValid = 1'b0;
      check_timeline(1'b1, exp_target(1'b0));
      m_cause = 4'd11; m_tval = 32'd0; m_pc = 32'h600; m_irq = 1'b1;
      step();
      interrupt = 1'b0;
      wbValid = 1'b0;
      check_timeline(1'b1, exp_target(1'b0));

      // Masked interrupt, then unmasked but waiting for a retiring instruction.
      mtvec = 32'h3001;
      interrupt = 1'b1; mstatusMIE = 1'b0; wbValid = 1'b1; wbNextPC = 32'h900;
      for (int i = 0; i < 20; i++) begin
         step();
         chk1("mask_strobe", controlReset, 1'b0);
         chk1("mask_busy", busy, 1'b0);
      end
      mstatusMIE = 1'b1;
      wbValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("nowb_busy", busy, 1'b0);
      end
      wbValid = 1'b1;
      m_cause = 4'd11; m_tval = 32'd0; m_pc = 32'h900; m_irq = 1'b1;
      step();
      interrupt = 1'b0;
      wbValid = 1'b0;
      check_timeline(1'b1, exp_target(1'b0));
      chk32("mask_target_const", 32'h3000 + 32'd44, exp_target(1'b0));

      // Asynchronous reset in the middle of the flush.
      mtvec = 32'h300;
      exceptionValid = 1'b1; exceptionCause = 4'd5; exceptionTval = 32'h55; exceptionPC = 32'h44;
      step();
      exceptionValid = 1'b0;
      chk1("rmf_strobe", controlReset, 1'b1);
      step();
      chk1("rmf_in_flush", pipelineFlush, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      m_cause = 4'd0; m_tval = 32'd0; m_pc = 32'd0; m_irq = 1'b0;
      chk1("rmf_pipelineFlush", pipelineFlush, 1'b0);
      chk1("rmf_busy", busy, 1'b0);
      chk1("rmf_controlReset", controlReset, 1'b0);
      chk1("rmf_redirectValid", redirectValid, 1'b0);
      chk32("rmf_redirectPC", redirectPC, 32'd0);
      chk_record();
      step();
      reset = 1'b1;
      for (int i = 0; i < F + 3; i++) begin
         step();
         chk1("post_rst_busy", busy, 1'b0);
         chk1("post_rst_redirect", redirectValid, 1'b0);
         chk1("post_rst_flush", pipelineFlush, 1'b0);
      end

      // Randomized back-to-back traffic.
      for (int i = 0; i < 12; i++) begin
         int kind;
         kind  = int'($urandom_range(0, 2));
         mtvec = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
         mepc  = $urandom;
         run_txn(kind, 4'($urandom), $urandom, $urandom, $urandom);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            wbValid = 1'($urandom_range(0, 1));
            step();
            chk1("gap_busy", busy, 1'b0);
            chk1("gap_strobe", controlReset, 1'b0);
         end
         wbValid = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequences every change of machine-mode control flow in the core: synchronous exceptions flagged at writeback, `mret` retirement, and the external machine interrupt. It arbitrates between these three requesters, drives the CSR file's trap-entry (`controlReset`) and trap-return (`mretSignal`) strobes with `mcause`, `mtval` and trap PC, flushes the pipeline, and issues a single fetch redirect. It sits between the writeback stage, the CSR file and the fetch unit.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `pipelineFlush` is held after the strobe cycle; legal range 1..15.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `exceptionValid`  in  1  writeback instruction carries a pending exception.
- `exceptionCause`  in  4  exception cause code.
- `exceptionTval`  in  32  faulting address/instruction.
- `exceptionPC`  in  32  PC of the faulting instruction.
- `mretValid`  in  1  `mret` retiring in writeback.
- `wbValid`  in  1  an instruction retires this cycle.
- `wbNextPC`  in  32  architectural next PC of the retiring instruction.
- `interrupt`  in  1  external interrupt, asynchronous level.
- `mstatusMIE`  in  1  global interrupt enable from the CSR file.
- `mtvec`  in  32  trap vector from the CSR file.
- `mepc`  in  32  return PC from the CSR file.
- `controlReset`  out  1  one-cycle trap-entry strobe to the CSR file.
- `mretSignal`  out  1  one-cycle trap-return strobe to the CSR file.
- `mcause`  out  4  registered cause code.
- `mcauseInterrupt`  out  1  high when the trap is an interrupt.
- `mtval`  out  32  registered trap value.
- `trapPC`  out  32  registered value for MEPC.
- `pipelineFlush`  out  1  kill all in-flight instructions.
- `redirectValid`  out  1  one-cycle fetch redirect.
- `redirectPC`  out  32  redirect target, word aligned.
- `busy`  out  1  high in every state other than IDLE. Fetch stalls while it is high.

## Operation
- `interrupt` passes through a 2-flop synchronizer (`intSync`), reset value 0.
- In IDLE, requests are arbitrated each cycle in fixed priority:
  - **Exception** (`exceptionValid`): capture `mcause=exceptionCause`, `mtval=exceptionTval`, `trapPC=exceptionPC`, `mcauseInterrupt=0`. Next state TRAP.
  - **mret** (`mretValid`, no exception): next state RETURN.
  - **Interrupt** (`intSync && mstatusMIE && wbValid`, neither of the above): capture `mcause=4'd11`, `mtval=0`, `trapPC=wbNextPC`, `mcauseInterrupt=1`. Next state TRAP.
- States:
  - **TRAP**: `controlReset=1`, `pipelineFlush=1`. Latch `redirectPC`:
    - `mtvec[1:0]==2'b01` and interrupt: `{mtvec[31:2],2'b00} + (mcause<<2)`, 32-bit wrap.
    - Otherwise: `{mtvec[31:2],2'b00}`.
    - Load flush counter with `FLUSH_CYCLES`. Next state FLUSH.
  - **RETURN**: `mretSignal=1`, `pipelineFlush=1`. Latch `redirectPC={mepc[31:2],2'b00}`. Load counter. Next state FLUSH.
  - **FLUSH**: `pipelineFlush=1`. Decrement the counter. Leave for REDIRECT on the cycle the counter equals 1.
  - **REDIRECT**: `redirectValid=1`, `pipelineFlush=0`. Next state IDLE.
- In any non-IDLE state, all request inputs are ignored; they are wrong-path.
  - An exception or mret is lost.
  - An interrupt level stays pending and is re-evaluated in IDLE.
- `mcause`, `mtval`, `trapPC` and `mcauseInterrupt` hold their last captured values until the next capture.
- Reset (asynchronous, any state): state IDLE, counter 0, every output 0, synchronizer cleared.

## Timing
- Exception or mret sampled in IDLE at edge T:
  - Strobe (`controlReset` or `mretSignal`) is high during cycle T+1.
  - `pipelineFlush` is high for cycles T+1 .. T+1+FLUSH_CYCLES.
  - `redirectValid` is high during cycle T+2+FLUSH_CYCLES.
  - `busy` falls at T+3+FLUSH_CYCLES; a new request is accepted in that cycle.
- Interrupt: rising `interrupt` becomes visible to arbitration 2 edges later, then follows the exception timeline.
- `mcause`, `mtval`, `trapPC` and `mcauseInterrupt` are stable from the strobe cycle onward.
- `redirectPC` is stable from the first FLUSH cycle through REDIRECT.
- The strobes and `redirectValid` never exceed one cycle.
- `controlReset` and `mretSignal` are never high in the same cycle.

## Test plan
- **Exception, FLUSH_CYCLES=2**: exceptionValid, cause 2, tval 0xDEADBEEF, PC 0x100, mtvec 0x80.
  - `controlReset` high exactly 1 cycle with mcause=2, mtval=0xDEADBEEF, trapPC=0x100.
  - Flush high for 3 cycles.
  - `redirectValid` with redirectPC=0x80 on the 4th cycle after the request.
- **mret**: mretValid, mepc 0x204.
  - `mretSignal` pulses once, `controlReset` stays 0.
  - redirectPC=0x204.
- **Vectored interrupt**: mtvec 0x1001, MIE=1, interrupt high, wbValid=1, wbNextPC 0x40.
  - Trap after 2 synchronizer cycles with mcause=11, mcauseInterrupt=1, trapPC=0x40.
  - redirectPC=0x102C.
- **Simultaneous requests**: exceptionValid, mretValid and a pending interrupt in the same cycle.
  - Exception wins; no mretSignal in the sequence.
  - Interrupt taken right after `busy` drops, provided MIE=1.
- **Masking**: interrupt high with MIE=0 for 20 cycles → no strobe. Raise MIE → trap taken at the next wbValid.
- **Reset mid-FLUSH**: assert reset low during FLUSH.
  - All outputs are 0 immediately, asynchronously.
  - After release, `busy`=0 and no redirect is emitted.
